regfile_32x32: RTL and testbench



---
 rtl/regfile_32x32_pkg.sv | 17 +
 rtl/regfile_32x32_if.sv | 24 ++
 rtl/regfile_32x32_read_port.sv | 32 +++
 rtl/regfile_32x32.sv | 60 ++++++
 tb/tb_regfile_32x32.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/regfile_32x32_pkg.sv
// Shared CPU definitions: register-file geometry, special register indices
// and the write-back bundle that the register file consumes.
package regfile_32x32_pkg;

  localparam int CPU_DATA_W = 32;
  localparam int CPU_ADDR_W = 5;

  localparam logic [CPU_ADDR_W-1:0] REG_ZERO = 5'd0;
  localparam logic [CPU_ADDR_W-1:0] REG_RA   = 5'd31;

  typedef struct packed {
    logic                  we;
    logic [CPU_ADDR_W-1:0] waddr;
    logic [CPU_DATA_W-1:0] wdata;
  } wr_port_t;

endpackage

// File: rtl/regfile_32x32_if.sv
// Register-file bus: one write port and two read ports.
// The master is the core (write-back plus operand fetch), the slave is the register file.
interface regfile_32x32_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic [ADDR_W-1:0] raddr1;
  logic [ADDR_W-1:0] raddr2;
  logic [DATA_W-1:0] rdata1;
  logic [DATA_W-1:0] rdata2;

  modport master (
    output we, waddr, wdata, raddr1, raddr2,
    input  rdata1, rdata2
  );

  modport slave (
    input  we, waddr, wdata, raddr1, raddr2,
    output rdata1, rdata2
  );
endinterface

// File: rtl/regfile_32x32_read_port.sv
// One combinational read port: it forces register 0 to zero and, when
// REGFILE_BYPASS_EN is defined, forwards the in-flight write-back data.
module regfile_read_port
  import regfile_32x32_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic [ADDR_W-1:0] i_raddr,
  input  logic [DATA_W-1:0] i_word,
`ifdef REGFILE_BYPASS_EN
  input  logic              i_fwd_en,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
`endif
  output logic [DATA_W-1:0] o_rdata
);

  logic w_is_zero;
  assign w_is_zero = (i_raddr == ADDR_W'(REG_ZERO));

`ifdef REGFILE_BYPASS_EN
  logic w_hit;
  assign w_hit = i_fwd_en && (i_waddr == i_raddr);

  // Index 0 takes priority, so a stray write to r0 can never be forwarded.
  assign o_rdata = w_is_zero ? '0 : (w_hit ? i_wdata : i_word);
`else
  assign o_rdata = w_is_zero ? '0 : i_word;
`endif

endmodule

// File: rtl/regfile_32x32.sv
// 32x32 MIPS general-purpose register file: async-clear storage, clocked
// write port, two combinational read ports (write-through when REGFILE_BYPASS_EN).
module regfile_32x32
  import regfile_32x32_pkg::*;
#(
  parameter int DATA_W = CPU_DATA_W,
  parameter int ADDR_W = CPU_ADDR_W
) (
  input  logic           clk,
  input  logic           rst,
  regfile_32x32_if.slave bus
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_mem [0:DEPTH-1];
  logic [DATA_W-1:0] w_word1;
  logic [DATA_W-1:0] w_word2;

  // Reset clears the whole array; r0 is never written afterwards, so it stays zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (bus.we && (bus.waddr != ADDR_W'(REG_ZERO))) begin
      r_mem[bus.waddr] <= bus.wdata;
    end
  end

  assign w_word1 = r_mem[bus.raddr1];
  assign w_word2 = r_mem[bus.raddr2];

`ifdef REGFILE_BYPASS_EN
  // A write that reset is about to discard must not be forwarded either.
  logic w_fwd_en;
  assign w_fwd_en = bus.we && !rst;
`endif

  regfile_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd1 (
    .i_raddr  (bus.raddr1),
    .i_word   (w_word1),
`ifdef REGFILE_BYPASS_EN
    .i_fwd_en (w_fwd_en),
    .i_waddr  (bus.waddr),
    .i_wdata  (bus.wdata),
`endif
    .o_rdata  (bus.rdata1)
  );

  regfile_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd2 (
    .i_raddr  (bus.raddr2),
    .i_word   (w_word2),
`ifdef REGFILE_BYPASS_EN
    .i_fwd_en (w_fwd_en),
    .i_waddr  (bus.waddr),
    .i_wdata  (bus.wdata),
`endif
    .o_rdata  (bus.rdata2)
  );

endmodule

// File: tb/tb_regfile_32x32.sv
// Directed bench for regfile_32x32 with a queue-based scoreboard; expectations
// follow REGFILE_BYPASS_EN when it is defined for the build.
module tb_regfile_32x32;
  import regfile_32x32_pkg::*;

  typedef struct {
    string       tag;
    bit          port;
    logic [31:0] exp;
  } chk_t;

  logic clk;
  logic rst;
  chk_t sb_q[$];
  event chk_ev;
  int   total;
  int   bad;

  regfile_32x32_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  regfile_32x32 #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: whenever the stimulus side announces a sample point, drain the queue.
  initial begin
    chk_t        c;
    logic [31:0] act;
    forever begin
      @(chk_ev);
      while (sb_q.size() > 0) begin
        c   = sb_q.pop_front();
        act = c.port ? bus.rdata2 : bus.rdata1;
        total++;
        if (act !== c.exp) begin
          bad++;
          $display("FAIL %s: rdata%0d got 0x%08h expected 0x%08h",
                   c.tag, c.port ? 2 : 1, act, c.exp);
        end
      end
    end
  end

  task automatic expect_rd(input bit port, input logic [4:0] a,
                           input logic [31:0] e, input string tag);
    chk_t c;
    if (port) bus.raddr2 = a;
    else      bus.raddr1 = a;
    #1;
    c.tag  = tag;
    c.port = port;
    c.exp  = e;
    sb_q.push_back(c);
    -> chk_ev;
    #1;
  endtask

  task automatic wr(input wr_port_t w);
    bus.we    = w.we;
    bus.waddr = w.waddr;
    bus.wdata = w.wdata;
    @(posedge clk);
    #1;
    bus.we = 1'b0;
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    rst        = 1'b1;
    bus.we     = 1'b0;
    bus.waddr  = '0;
    bus.wdata  = '0;
    bus.raddr1 = '0;
    bus.raddr2 = '0;

    #3;
    expect_rd(0, 5'd5, 32'h0, "reset_r5");
    expect_rd(1, REG_RA, 32'h0, "reset_r31");
    @(negedge clk);
    rst = 1'b0;
    expect_rd(0, 5'd12, 32'h0, "post_reset_r12");

    // Async reset clears a freshly written register without a clock edge.
    wr('{we: 1'b1, waddr: 5'd5, wdata: 32'hDEADBEEF});
    expect_rd(0, 5'd5, 32'hDEADBEEF, "r5_written");
    rst = 1'b1;
    expect_rd(0, 5'd5, 32'h0, "async_reset_r5");
    rst = 1'b0;
    expect_rd(1, 5'd5, 32'h0, "after_reset_r5");

    // Writes to r0 are dropped and disturb nothing else.
    wr('{we: 1'b1, waddr: 5'd6, wdata: 32'h600D0006});
    wr('{we: 1'b1, waddr: REG_ZERO, wdata: 32'hFFFFFFFF});
    expect_rd(0, REG_ZERO, 32'h0, "r0_port1");
    expect_rd(1, REG_ZERO, 32'h0, "r0_port2");
    expect_rd(0, 5'd6, 32'h600D0006, "r6_untouched");

    wr('{we: 1'b1, waddr: REG_RA, wdata: 32'h00400010});
    wr('{we: 1'b1, waddr: 5'd8, wdata: 32'h12345678});
    expect_rd(0, REG_RA, 32'h00400010, "r31_link");
    expect_rd(1, 5'd8, 32'h12345678, "r8_port2");
    expect_rd(0, 5'd8, 32'h12345678, "r8_both_p1");
    expect_rd(1, 5'd8, 32'h12345678, "r8_both_p2");

    wr('{we: 1'b1, waddr: 5'd9, wdata: 32'hA5A5A5A5});
    wr('{we: 1'b0, waddr: 5'd9, wdata: 32'h00000000});
    expect_rd(0, 5'd9, 32'hA5A5A5A5, "r9_we_low");

    // Same-cycle read-after-write on r10.
    wr('{we: 1'b1, waddr: 5'd10, wdata: 32'h00000001});
    bus.we    = 1'b1;
    bus.waddr = 5'd10;
    bus.wdata = 32'h00000002;
`ifdef REGFILE_BYPASS_EN
    expect_rd(0, 5'd10, 32'h00000002, "raw_before_edge");
`else
    expect_rd(0, 5'd10, 32'h00000001, "raw_before_edge");
`endif
    expect_rd(1, 5'd9, 32'hA5A5A5A5, "raw_other_port");
    @(posedge clk);
    #1;
    bus.we = 1'b0;
    expect_rd(0, 5'd10, 32'h00000002, "raw_after_edge");

    // Reset held across an edge beats a concurrent write.
    @(negedge clk);
    bus.we    = 1'b1;
    bus.waddr = 5'd3;
    bus.wdata = 32'h00000077;
    rst       = 1'b1;
    @(posedge clk);
    #1;
    bus.we = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    expect_rd(0, 5'd3, 32'h0, "rst_beats_write_r3");
    expect_rd(1, 5'd10, 32'h0, "rst_cleared_r10");

    wr('{we: 1'b1, waddr: 5'd3, wdata: 32'h00000077});
    expect_rd(0, 5'd3, 32'h00000077, "r3_after_release");

    #2;
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL sb_drain: %0d entries left, expected 0", sb_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
